// File: rtl/wb_arb_pkg.sv
// ============================================================================
// wb_arb_pkg : shared types and mux-select constants for the writeback arbiter
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WAIT  = 2'd1,
        WB_FORCE = 2'd2
    } wb_state_e;

    localparam logic [2:0] SEL_ALU  = 3'b000;
    localparam logic [2:0] SEL_LOAD = 3'b001;
    localparam logic [2:0] SEL_PC4  = 3'b010;
    localparam logic [2:0] SEL_IMM  = 3'b011;
    localparam logic [2:0] SEL_LLU  = 3'b100;

    // Maps the W-stage result source onto the d0..d3 inputs of the result mux.
    function automatic logic [2:0] pipe_sel(input logic [1:0] src);
        logic [2:0] sel;
        sel = SEL_ALU;
        case (src)
            2'b00:   sel = SEL_ALU;
            2'b01:   sel = SEL_LOAD;
            2'b10:   sel = SEL_PC4;
            default: sel = SEL_IMM;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_starve_cnt.sv
// ============================================================================
// wb_starve_cnt : saturating count of consecutive denied LLU cycles; hit flags
//                 the increment that reaches LIMIT
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc && (int'(r_cnt) < LIMIT)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign hit = inc && ((int'(r_cnt) + 1) >= LIMIT);

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : register-file write-port arbiter between W stage and LLU
//              WB_ARB_STARVE_EN enables the starvation counter and FORCE state
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic [1:0]            result_src_w,
    input  logic                  llu_valid,
    input  logic [REG_ADDR_W-1:0] llu_rd,
    output logic                  llu_ready,
    output logic [2:0]            result_sel,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic                  stall_req
);

    logic w_pipe_wr;
    logic w_force;

    assign w_pipe_wr = reg_write_w && (rd_w != '0);

`ifdef WB_ARB_STARVE_EN
    wb_state_e r_state;
    logic      w_denied;
    logic      w_llu_hs;
    logic      w_hit;

    assign w_force  = (r_state == WB_FORCE);
    assign w_denied = llu_valid && !llu_ready;
    assign w_llu_hs = llu_valid && llu_ready;

    wb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_denied),
        .clr   (w_llu_hs || w_force),
        .hit   (w_hit)
    );

    // WAIT drops back to IDLE on any non-denied cycle: either the handshake
    // happened or the request went away.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WB_IDLE;
        end else begin
            case (r_state)
                WB_IDLE, WB_WAIT: begin
                    if (w_denied) begin
                        r_state <= w_hit ? WB_FORCE : WB_WAIT;
                    end else begin
                        r_state <= WB_IDLE;
                    end
                end
                WB_FORCE: r_state <= WB_IDLE;
                default:  r_state <= WB_IDLE;
            endcase
        end
    end
`else
    logic w_unused_limit;

    assign w_force        = 1'b0;
    assign w_unused_limit = (STARVE_LIMIT > 0);
`endif

    always_comb begin
        llu_ready  = 1'b0;
        rf_we      = 1'b0;
        result_sel = SEL_ALU;
        rf_waddr   = '0;
        stall_req  = 1'b0;
        if (!reset) begin
            if (w_force || !w_pipe_wr) begin
                stall_req = w_force;
                llu_ready = 1'b1;
                if (llu_valid) begin
                    result_sel = SEL_LLU;
                    rf_we      = (llu_rd != '0);
                    rf_waddr   = llu_rd;
                end
            end else begin
                result_sel = pipe_sel(result_src_w);
                rf_we      = 1'b1;
                rf_waddr   = rd_w;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter : directed plus random stimulus against a behavioural model
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int REG_ADDR_W   = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  reg_write_w;
    logic [REG_ADDR_W-1:0] rd_w;
    logic [1:0]            result_src_w;
    logic                  llu_valid;
    logic [REG_ADDR_W-1:0] llu_rd;
    logic                  llu_ready;
    logic [2:0]            result_sel;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic                  stall_req;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int waits    = 0;  // consecutive cycles the pending LLU result has been refused
    int n_stall  = 0;

    wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .REG_ADDR_W   (REG_ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_src_w (result_src_w),
        .llu_valid    (llu_valid),
        .llu_rd       (llu_rd),
        .llu_ready    (llu_ready),
        .result_sel   (result_sel),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .stall_req    (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        logic                  pw;
        logic                  forced;
        logic                  e_ready, e_we, e_stall, hs;
        logic [2:0]            e_sel;
        logic [REG_ADDR_W-1:0] e_addr;
        @(negedge clk);
        pw = reg_write_w && (rd_w != 0);
`ifdef WB_ARB_STARVE_EN
        forced = (waits >= STARVE_LIMIT);
`else
        forced = 1'b0;
`endif
        e_ready = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_sel = 3'b000; e_addr = '0;
        if (!reset) begin
            if (pw && !forced) begin
                e_sel  = {1'b0, result_src_w};
                e_we   = 1'b1;
                e_addr = rd_w;
            end else begin
                e_ready = 1'b1;
                e_stall = forced;
                if (llu_valid) begin
                    e_sel  = 3'b100;
                    e_we   = (llu_rd != 0);
                    e_addr = llu_rd;
                end
            end
        end
        check_value("llu_ready",  32'(llu_ready),  32'(e_ready));
        check_value("rf_we",      32'(rf_we),      32'(e_we));
        check_value("result_sel", 32'(result_sel), 32'(e_sel));
        check_value("rf_waddr",   32'(rf_waddr),   32'(e_addr));
        check_value("stall_req",  32'(stall_req),  32'(e_stall));
        if (stall_req === 1'b1) n_stall++;
        @(posedge clk);
        hs = !reset && llu_valid && e_ready;
        if (reset || hs) begin
            waits = 0;
        end else if (llu_valid && waits < STARVE_LIMIT) begin
            waits++;
        end
        #1;
        if (hs) llu_valid = 1'b0;
        cyc++;
    endtask

    task automatic drive(input logic rw, input int rd, input int src, input logic lv, input int lrd);
        reg_write_w  = rw;
        rd_w         = REG_ADDR_W'(rd);
        result_src_w = 2'(src);
        llu_valid    = lv;
        llu_rd       = REG_ADDR_W'(lrd);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, 0, 1'b1, 7);
        step();
        step();
        reset = 1'b0;
        step();                                   // held LLU granted on a free port

        drive(1'b1, 5, 1, 1'b0, 0);               // pipeline only
        step();
        drive(1'b0, 0, 0, 1'b1, 7);               // LLU only, zero latency
        step();

        drive(1'b1, 3, 0, 1'b1, 9);               // sustained conflict
        n_stall = 0;
        repeat (10) step();
`ifdef WB_ARB_STARVE_EN
        check_value("conflict_stalls", 32'(n_stall), 32'd1);
`else
        check_value("conflict_stalls", 32'(n_stall), 32'd0);
`endif
        reg_write_w = 1'b0;
        step();

        drive(1'b1, 0, 2, 1'b1, 4);               // write to x0 leaves port free
        step();
        drive(1'b0, 0, 0, 1'b1, 0);               // LLU to x0: accepted, no write
        step();

        drive(1'b1, 6, 3, 1'b1, 11);              // reset while forced
        repeat (STARVE_LIMIT) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        reg_write_w = 1'b0;
        step();

        drive(1'b1, 8, 2, 1'b1, 12);              // single denied cycle then free
        step();
        reg_write_w = 1'b0;
        step();

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom % 64) == 0;
            reg_write_w  = ($urandom % 4) != 0;
            rd_w         = (($urandom % 5) == 0) ? '0 : REG_ADDR_W'($urandom);
            result_src_w = 2'($urandom);
            if (!llu_valid) begin
                llu_valid = 1'($urandom);
                llu_rd    = (($urandom % 6) == 0) ? '0 : REG_ADDR_W'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter and select controller for the register-file write path. Arbitrates each cycle between the in-order pipeline's W stage and the long-latency unit (LLU: mul/div) for the single register-file write port. Drives the 3-bit select of the five-input writeback result mux: pipeline sources on d0–d3, LLU on d4. Sits between the W stage, the LLU completion interface and the hazard unit. Requests a pipeline stall when the LLU must be forced through.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied LLU cycles before a forced grant; legal range ≥1; used only with WB_ARB_STARVE_EN.
- REG_ADDR_W, 5: register address width.

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- reg_write_w, input, 1: W-stage instruction writes the register file.
- rd_w, input, REG_ADDR_W: W-stage destination register.
- result_src_w, input, 2: W-stage result source; 00 ALU, 01 load, 10 PC+4, 11 immediate.
- llu_valid, input, 1: LLU result available; held until handshake.
- llu_rd, input, REG_ADDR_W: LLU destination register.
- llu_ready, output, 1: arbiter accepts the LLU result this cycle.
- result_sel, output, 3: mux select; {0,result_src_w} for pipeline, 3'b100 for LLU, 3'b000 when idle.
- rf_we, output, 1: register-file write enable.
- rf_waddr, output, REG_ADDR_W: register-file write address.
- stall_req, output, 1: stall request to the hazard unit.

## Operation
- pipe_wr = reg_write_w & (rd_w != 0). llu_hs = llu_valid & llu_ready.
- Writes to x0 are never issued. An LLU handshake with llu_rd == 0 is accepted and rf_we stays 0.
- States:
  - IDLE: no denied LLU request.
  - WAIT: LLU denied at least once and still pending.
  - FORCE: LLU owns the port.
- IDLE and WAIT behaviour:
  - If !pipe_wr: llu_ready=1. If llu_valid, grant the LLU: result_sel=100, rf_waddr=llu_rd.
  - If pipe_wr: grant the pipeline: result_sel={0,result_src_w}, rf_waddr=rd_w, llu_ready=0.
- FORCE behaviour: stall_req=1, llu_ready=1, LLU granted. Pipeline write is suppressed; the W instruction is held by the stall and writes the following cycle.
- Transitions:
  - IDLE→WAIT: llu_valid & pipe_wr.
  - WAIT→IDLE: llu_hs.
  - WAIT→FORCE: denied count reaches STARVE_LIMIT.
  - FORCE→IDLE: always, after one cycle, because llu_valid is held until handshake.
- Denied counter:
  - Increments on each cycle with llu_valid & !llu_ready.
  - Clears on llu_hs or reset.
  - Saturates at STARVE_LIMIT.
- Both requesters idle: rf_we=0, result_sel=000, rf_waddr=0.
- WAW ordering between the LLU and a younger pipeline write to the same rd is prevented upstream by the hazard unit. The arbiter performs no address comparison.

## Timing
- Outputs are combinational from the registered state, the counter and the current inputs. Grant and write happen in the same cycle; the register file captures at the next edge.
- LLU latency with the port free: 0 cycles (ready in the same cycle as valid).
- Worst-case LLU wait with the macro: STARVE_LIMIT denied cycles, then 1 FORCE cycle.
- Reset cycle: llu_ready=0, rf_we=0, stall_req=0, result_sel=000, rf_waddr=0. State→IDLE, counter→0.
- Reset mid-WAIT or mid-FORCE: any pending LLU result is re-arbitrated from IDLE after reset deasserts. No write occurs in the reset cycle.
- STARVE_LIMIT=1: FORCE follows the first denied cycle.

## Configuration
- WB_ARB_STARVE_EN defined:
  - Denied counter and FORCE state are present.
  - stall_req is driven as specified above.
- WB_ARB_STARVE_EN undefined:
  - No counter and no FORCE state.
  - stall_req is tied to 0.
  - The pipeline always has priority; the LLU is granted only in cycles where pipe_wr=0.
  - STARVE_LIMIT is ignored.

## Structure
- Package wb_arb_pkg holds:
  - the state enum (WB_IDLE, WB_WAIT, WB_FORCE);
  - select constants SEL_ALU=000, SEL_LOAD=001, SEL_PC4=010, SEL_IMM=011, SEL_LLU=100.
- Optional sub-module wb_starve_cnt: saturating counter with inc, clr and hit ports. It is instantiated only under WB_ARB_STARVE_EN.

## Test plan
- Only the pipeline writes: reg_write_w=1, rd_w=5, result_src_w=01 → rf_we=1, rf_waddr=5, result_sel=001, llu_ready=0.
- Only the LLU: llu_valid=1, llu_rd=7, reg_write_w=0 → llu_ready=1, rf_we=1, rf_waddr=7, result_sel=100 in the same cycle; state stays IDLE.
- Conflict, macro on, STARVE_LIMIT=4: pipe_wr continuously high with llu_valid held → 4 pipeline grants, then 1 cycle with stall_req=1 and an LLU write, then IDLE.
- Conflict, macro off: pipe_wr high for 10 cycles → llu_ready=0 and stall_req=0 throughout. The LLU is granted in the first cycle with reg_write_w=0.
- x0 handling: rd_w=0 with reg_write_w=1 → treated as no write, so a waiting LLU is granted. llu_rd=0 → llu_ready=1 with rf_we=0.
- Reset asserted during FORCE → all outputs 0 in that cycle. The next cycle starts from IDLE, the counter at 0, and the held LLU is granted if the port is free.
